// File: rtl/vgachargen_pkg.sv
// Shared 640x480 raster constants, address widths and the sync/enable bundle
// that travels down the pixel pipeline.
package vgachargen_pkg;

  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HR = 96;
  localparam int HB = 48;
  localparam int HTOTAL = HD + HF + HR + HB;
  localparam int VD = 480;
  localparam int VF = 10;
  localparam int VR = 2;
  localparam int VB = 33;
  localparam int VTOTAL = VD + VF + VR + VB;

  localparam int VGA_MAX_H_WIDTH = $clog2(HTOTAL);
  localparam int VGA_MAX_V_WIDTH = $clog2(VTOTAL);

  localparam int CH_H_PIXELS = HD / 8;
  localparam int CH_V_ROWS = VD / 16;
  localparam int CH_MAP_ADDR_WIDTH = $clog2(CH_H_PIXELS * CH_V_ROWS);
  localparam int BITMAP_ADDR_WIDTH = 7;

  localparam logic [VGA_MAX_H_WIDTH-1:0] H_VISIBLE = VGA_MAX_H_WIDTH'(HD);
  localparam logic [VGA_MAX_H_WIDTH-1:0] H_LAST = VGA_MAX_H_WIDTH'(HTOTAL - 1);
  localparam logic [VGA_MAX_H_WIDTH-1:0] HSYNC_START = VGA_MAX_H_WIDTH'(HD + HF);
  localparam logic [VGA_MAX_H_WIDTH-1:0] HSYNC_END = VGA_MAX_H_WIDTH'(HD + HF + HR);
  localparam logic [VGA_MAX_V_WIDTH-1:0] V_VISIBLE = VGA_MAX_V_WIDTH'(VD);
  localparam logic [VGA_MAX_V_WIDTH-1:0] V_LAST = VGA_MAX_V_WIDTH'(VTOTAL - 1);
  localparam logic [VGA_MAX_V_WIDTH-1:0] VSYNC_START = VGA_MAX_V_WIDTH'(VD + VF);
  localparam logic [VGA_MAX_V_WIDTH-1:0] VSYNC_END = VGA_MAX_V_WIDTH'(VD + VF + VR);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0};

endpackage

// File: rtl/vgachargen_delay_line.sv
// Enable-gated shift register; DEPTH=0 collapses to a wire so callers can
// tune pipeline alignment without special-casing.
module vgachargen_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign q_o = d_i;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= RESET_VAL;
        end else if (en_i) begin
          stage_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vgachargen_timing.sv
// 640x480 raster counters feeding the char-map/bitmap lookup, with sync and
// display-enable delayed to match it. VGACHARGEN_BLINK_EN adds blink_o.
module vgachargen_timing
  import vgachargen_pkg::*;
#(
  parameter int PIPE_DELAY = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         pix_en_i,
  output logic [VGA_MAX_H_WIDTH-1:0]   hcount_o,
  output logic [VGA_MAX_V_WIDTH-1:0]   vcount_o,
  output logic                         visible_o,
  output logic [CH_MAP_ADDR_WIDTH-1:0] ch_map_addr_o,
  output logic [BITMAP_ADDR_WIDTH-1:0] bitmap_addr_o,
  output logic                         hsync_o,
  output logic                         vsync_o,
  output logic                         de_o,
  output logic                         frame_start_o
`ifdef VGACHARGEN_BLINK_EN
  ,
  output logic                         blink_o
`endif
);

  logic [VGA_MAX_H_WIDTH-1:0] hcount_q, hcount_d;
  logic [VGA_MAX_V_WIDTH-1:0] vcount_q, vcount_d;
  logic h_last, v_last;
  vga_ctrl_t ctrl_raw, ctrl_dly;

  assign h_last = (hcount_q == H_LAST);
  assign v_last = (vcount_q == V_LAST);

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_i) begin
      if (h_last) begin
        hcount_d = '0;
        vcount_d = v_last ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign frame_start_o = pix_en_i & h_last & v_last & ~rst_i;
  assign hcount_o = hcount_q;
  assign vcount_o = vcount_q;
  assign visible_o = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);

  // row*80 as (row<<6)+(row<<4); outside the active area both addresses read 0
  logic [5:0] char_row;
  logic [6:0] char_col;
  assign char_row = vcount_q[9:4];
  assign char_col = hcount_q[9:3];

  always_comb begin
    ch_map_addr_o = '0;
    bitmap_addr_o = '0;
    if (visible_o) begin
      ch_map_addr_o = {char_row, 6'b0} + {2'b0, char_row, 4'b0} + {5'b0, char_col};
      bitmap_addr_o = {vcount_q[3:0], hcount_q[2:0]};
    end
  end

  always_comb begin
    ctrl_raw.hsync = !((hcount_q >= HSYNC_START) && (hcount_q < HSYNC_END));
    ctrl_raw.vsync = !((vcount_q >= VSYNC_START) && (vcount_q < VSYNC_END));
    ctrl_raw.de = visible_o;
  end

  vgachargen_delay_line #(
    .WIDTH    ($bits(vga_ctrl_t)),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(CTRL_IDLE)
  ) u_ctrl_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .en_i (pix_en_i),
    .d_i  (ctrl_raw),
    .q_o  (ctrl_dly)
  );

  assign hsync_o = ctrl_dly.hsync;
  assign vsync_o = ctrl_dly.vsync;
  assign de_o = ctrl_dly.de;

`ifdef VGACHARGEN_BLINK_EN
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d = blink_q;
    if (frame_start_o) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      blink_cnt_q <= '0;
      blink_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_o = blink_q;
`endif

endmodule

// File: tb/tb_vgachargen_timing.sv
// Self-checking bench for vgachargen_timing: tick-indexed raster model plus
// forced-position checks for the far corners of the frame.
module tb_vgachargen_timing;

  localparam int PD = 2;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic pix_en_i = 1'b0;
  logic [9:0] hcount_o, vcount_o;
  logic visible_o;
  logic [11:0] ch_map_addr_o;
  logic [6:0] bitmap_addr_o;
  logic hsync_o, vsync_o, de_o, frame_start_o;
`ifdef VGACHARGEN_BLINK_EN
  logic blink_o;
`endif

  int total = 0;
  int bad = 0;
  logic [9:0] fh, fv;

  always #5 clk = ~clk;

  vgachargen_timing #(.PIPE_DELAY(PD), .BLINK_FRAMES(BF)) dut (
    .clk_i(clk), .rst_i(rst_i), .pix_en_i(pix_en_i),
    .hcount_o(hcount_o), .vcount_o(vcount_o), .visible_o(visible_o),
    .ch_map_addr_o(ch_map_addr_o), .bitmap_addr_o(bitmap_addr_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .frame_start_o(frame_start_o)
`ifdef VGACHARGEN_BLINK_EN
    , .blink_o(blink_o)
`endif
  );

  // Position after t pixel ticks since reset release.
  function automatic int mh(int t); return t % 800; endfunction
  function automatic int mv(int t); return (t / 800) % 525; endfunction
  function automatic bit mvis(int t); return mh(t) < 640 && mv(t) < 480; endfunction
  function automatic bit mhs(int t);
    if (t < 0) return 1'b1;
    return !(mh(t) >= 656 && mh(t) < 752);
  endfunction
  function automatic bit mvs(int t);
    if (t < 0) return 1'b1;
    return !(mv(t) >= 490 && mv(t) < 492);
  endfunction
  function automatic bit mde(int t);
    if (t < 0) return 1'b0;
    return mvis(t);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    pix_en_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pix_en_i = 1'b0;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1;
    pix_en_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (hcount_o !== 10'd0) begin bad++; $display("FAIL rst_hcount got=%0d exp=0", hcount_o); end
    total++; if (vcount_o !== 10'd0) begin bad++; $display("FAIL rst_vcount got=%0d exp=0", vcount_o); end
    total++; if (visible_o !== 1'b1) begin bad++; $display("FAIL rst_visible got=%b exp=1", visible_o); end
    total++; if (ch_map_addr_o !== 12'd0) begin bad++; $display("FAIL rst_chmap got=%0d exp=0", ch_map_addr_o); end
    total++; if (bitmap_addr_o !== 7'd0) begin bad++; $display("FAIL rst_bitmap got=%0d exp=0", bitmap_addr_o); end
    total++; if ({hsync_o, vsync_o, de_o} !== 3'b110) begin bad++; $display("FAIL rst_ctrl got=%b exp=110", {hsync_o, vsync_o, de_o}); end
    total++; if (frame_start_o !== 1'b0) begin bad++; $display("FAIL rst_frame_start got=%b exp=0", frame_start_o); end
    pix_en_i = 1'b0;
    rst_i = 1'b0;
  endtask

  // mode 0: pix_en always on; 1: one clock in four; 2: random
  task automatic test_stream(int mode, int nclk);
    int t = 0;
    int hs_low = 0;
    int hs_first = -1;
    logic [42:0] act, exp_v;
    bit fs_exp;
    do_reset();
    for (int c = 0; c < nclk; c++) begin
      act = {hcount_o, vcount_o, visible_o, ch_map_addr_o, bitmap_addr_o, hsync_o, vsync_o, de_o};
      exp_v = {10'(mh(t)), 10'(mv(t)), mvis(t),
               mvis(t) ? 12'((mv(t) / 16) * 80 + mh(t) / 8) : 12'd0,
               mvis(t) ? 7'((mv(t) % 16) * 8 + mh(t) % 8) : 7'd0,
               mhs(t - PD), mvs(t - PD), mde(t - PD)};
      total++;
      if (act !== exp_v) begin
        bad++;
        $display("FAIL stream%0d_state clk=%0d tick=%0d got=%h exp=%h", mode, c, t, act, exp_v);
      end
      if (mode == 0 && hsync_o === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = t;
      end
      case (mode)
        0: pix_en_i = 1'b1;
        1: pix_en_i = (c % 4 == 3);
        default: pix_en_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      fs_exp = pix_en_i && mh(t) == 799 && mv(t) == 524;
      total++;
      if (frame_start_o !== fs_exp) begin
        bad++;
        $display("FAIL stream%0d_frame_start clk=%0d got=%b exp=%b", mode, c, frame_start_o, fs_exp);
      end
      @(posedge clk);
      if (pix_en_i) t++;
      @(negedge clk);
    end
    pix_en_i = 1'b0;
    if (mode == 0) begin
      total++; if (hs_low !== 192) begin bad++; $display("FAIL hsync_low_count got=%0d exp=192", hs_low); end
      total++; if (hs_first !== 656 + PD) begin bad++; $display("FAIL hsync_first_low got=%0d exp=%0d", hs_first, 656 + PD); end
    end
  endtask

  task automatic test_force_position();
    int h, v, ech, ebm;
    do_reset();
    pix_en_i = 1'b0;
    fh = 10'd639; fv = 10'd479;
    force dut.hcount_q = fh; force dut.vcount_q = fv;
    #1;
    total++; if (ch_map_addr_o !== 12'd2399) begin bad++; $display("FAIL corner_chmap got=%0d exp=2399", ch_map_addr_o); end
    total++; if (bitmap_addr_o !== 7'd127) begin bad++; $display("FAIL corner_bitmap got=%0d exp=127", bitmap_addr_o); end
    fh = 10'd8; fv = 10'd17;
    force dut.hcount_q = fh; force dut.vcount_q = fv;
    #1;
    total++; if (ch_map_addr_o !== 12'd81) begin bad++; $display("FAIL pos8_17_chmap got=%0d exp=81", ch_map_addr_o); end
    total++; if (bitmap_addr_o !== 7'd8) begin bad++; $display("FAIL pos8_17_bitmap got=%0d exp=8", bitmap_addr_o); end
    for (int i = 0; i < 16; i++) begin
      if (i < 12) begin h = $urandom_range(0, 639); v = $urandom_range(0, 479); end
      else begin h = $urandom_range(640, 799); v = $urandom_range(0, 524); end
      fh = 10'(h); fv = 10'(v);
      force dut.hcount_q = fh; force dut.vcount_q = fv;
      #1;
      ech = (h < 640 && v < 480) ? (v / 16) * 80 + h / 8 : 0;
      ebm = (h < 640 && v < 480) ? (v % 16) * 8 + h % 8 : 0;
      total++;
      if ({visible_o, ch_map_addr_o, bitmap_addr_o} !== {h < 640 && v < 480, 12'(ech), 7'(ebm)}) begin
        bad++;
        $display("FAIL rand_pos h=%0d v=%0d got vis=%b ch=%0d bm=%0d exp ch=%0d bm=%0d",
                 h, v, visible_o, ch_map_addr_o, bitmap_addr_o, ech, ebm);
      end
    end
    release dut.hcount_q; release dut.vcount_q;
  endtask

  task automatic test_frame_wrap();
    do_reset();
    fh = 10'd799; fv = 10'd524;
    force dut.hcount_q = fh; force dut.vcount_q = fv;
    pix_en_i = 1'b1; #1;
    total++; if (frame_start_o !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%b exp=1", frame_start_o); end
    pix_en_i = 1'b0; #1;
    total++; if (frame_start_o !== 1'b0) begin bad++; $display("FAIL wrap_no_en got=%b exp=0", frame_start_o); end
    fh = 10'd798;
    force dut.hcount_q = fh;
    pix_en_i = 1'b1; #1;
    total++; if (frame_start_o !== 1'b0) begin bad++; $display("FAIL wrap_early got=%b exp=0", frame_start_o); end
    // park on a vsync line, a hsync column and a visible pixel in turn
    fh = 10'd100; fv = 10'd490;
    force dut.hcount_q = fh; force dut.vcount_q = fv;
    repeat (PD + 1) @(posedge clk);
    @(negedge clk);
    total++; if ({hsync_o, vsync_o, de_o} !== 3'b100) begin bad++; $display("FAIL park_vsync got=%b exp=100", {hsync_o, vsync_o, de_o}); end
    fh = 10'd700; fv = 10'd100;
    force dut.hcount_q = fh; force dut.vcount_q = fv;
    repeat (PD + 1) @(posedge clk);
    @(negedge clk);
    total++; if ({hsync_o, vsync_o, de_o} !== 3'b010) begin bad++; $display("FAIL park_hsync got=%b exp=010", {hsync_o, vsync_o, de_o}); end
    fh = 10'd10; fv = 10'd10;
    force dut.hcount_q = fh; force dut.vcount_q = fv;
    repeat (PD + 1) @(posedge clk);
    @(negedge clk);
    total++; if ({hsync_o, vsync_o, de_o} !== 3'b111) begin bad++; $display("FAIL park_visible got=%b exp=111", {hsync_o, vsync_o, de_o}); end
    pix_en_i = 1'b0;
    release dut.hcount_q; release dut.vcount_q;
  endtask

  task automatic test_reset_mid(int at_t);
    do_reset();
    pix_en_i = 1'b1;
    repeat (at_t) @(posedge clk);
    @(negedge clk);
    total++;
    if ({hcount_o, vcount_o, hsync_o, de_o} !== {10'(mh(at_t)), 10'(mv(at_t)), mhs(at_t - PD), mde(at_t - PD)}) begin
      bad++;
      $display("FAIL mid_pre%0d got h=%0d v=%0d hs=%b de=%b", at_t, hcount_o, vcount_o, hsync_o, de_o);
    end
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({hcount_o, vcount_o, hsync_o, vsync_o, de_o, frame_start_o} !== {20'd0, 4'b1100}) begin
      bad++;
      $display("FAIL mid_reset%0d got h=%0d v=%0d hs=%b vs=%b de=%b fs=%b",
               at_t, hcount_o, vcount_o, hsync_o, vsync_o, de_o, frame_start_o);
    end
    @(negedge clk);
    rst_i = 1'b0;
    pix_en_i = 1'b0;
  endtask

`ifdef VGACHARGEN_BLINK_EN
  task automatic test_blink();
    do_reset();
    total++; if (blink_o !== 1'b0) begin bad++; $display("FAIL blink_reset got=%b exp=0", blink_o); end
    fh = 10'd799; fv = 10'd524;
    force dut.hcount_q = fh; force dut.vcount_q = fv;
    pix_en_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (blink_o !== 1'((k / BF) % 2)) begin
        bad++;
        $display("FAIL blink_after_%0d got=%b exp=%b", k, blink_o, 1'((k / BF) % 2));
      end
    end
    pix_en_i = 1'b0;
    release dut.hcount_q; release dut.vcount_q;
    do_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_stream(0, 1700);
    test_stream(1, 3600);
    test_stream(2, 3000);
    test_force_position();
    test_frame_wrap();
    test_reset_mid(1100);
    test_reset_mid(1500);
`ifdef VGACHARGEN_BLINK_EN
    test_blink();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
